// File: rtl/bist_session_ctrl_pkg.sv
// bist_session_ctrl_pkg: shared defaults, session state encoding and sizing helper
package bist_session_ctrl_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_PATTERNS = 255;
  localparam int DEF_FLUSH_CYC = 2;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_RUN     = 3'd2,
    S_FLUSH   = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_e;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bist_session_ctrl_if.sv
// bist_session_ctrl_if: session control/status bundle between a BIST owner and the sequencer
interface bist_session_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic [WIDTH-1:0] golden;
  logic             cut_busy;
  logic [WIDTH-1:0] misr_sig;
  logic             lfsr_load;
  logic             lfsr_en;
  logic             misr_clr;
  logic             misr_en;
  logic [CNT_W-1:0] pat_cnt;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] sig_out;
  modport master (
    output start, golden, cut_busy, misr_sig,
    input  lfsr_load, lfsr_en, misr_clr, misr_en, pat_cnt, busy, done, pass, sig_out
  );
  modport slave (
    input  start, golden, cut_busy, misr_sig,
    output lfsr_load, lfsr_en, misr_clr, misr_en, pat_cnt, busy, done, pass, sig_out
  );
endinterface

// File: rtl/bist_session_ctrl_pattern_cnt.sv
// bist_pattern_cnt: accepted-vector counter with terminal flag on the last vector of a session
module bist_pattern_cnt #(
  parameter int CNT_W = 8,
  parameter int PATTERNS = 255
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PATTERNS - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clock or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
  assign tc = (PATTERNS != 0) && (cnt_q == LAST);
endmodule

// File: rtl/bist_session_ctrl.sv
// bist_session_ctrl: sequences seed, pattern run, MISR flush and signature compare for one BIST session
module bist_session_ctrl
  import bist_session_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int PATTERNS = DEF_PATTERNS,
  parameter int FLUSH_CYC = DEF_FLUSH_CYC
) (
  input logic clock,
  input logic rst,
  bist_session_ctrl_if.slave bus
);
  localparam int FL_W = cnt_w(FLUSH_CYC);
  localparam state_e AFTER_RUN = (FLUSH_CYC == 0) ? S_COMPARE : S_FLUSH;
  localparam state_e AFTER_INIT = (PATTERNS == 0) ? AFTER_RUN : S_RUN;
  state_e           state_q, state_d;
  logic [FL_W-1:0]  fl_q, fl_d;
  logic             pass_q, pass_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             accept;
  assign accept = (state_q == S_RUN) && !bus.cut_busy;
  always_comb begin
    state_d = state_q;
    fl_d = '0;
    pass_d = pass_q;
    sig_d = sig_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (bus.start) begin
        state_d = S_INIT;
        pass_d = 1'b0;
      end
      S_INIT: state_d = AFTER_INIT;
      S_RUN: if (accept && tc) state_d = AFTER_RUN;
      S_FLUSH: begin
        fl_d = fl_q + FL_W'(1);
        if (fl_q == FL_W'(FLUSH_CYC - 1)) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        state_d = S_DONE;
        sig_d = bus.misr_sig;
        pass_d = bus.misr_sig == bus.golden;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      fl_q <= '0;
      pass_q <= 1'b0;
      sig_q <= '0;
    end else begin
      state_q <= state_d;
      fl_q <= fl_d;
      pass_q <= pass_d;
      sig_q <= sig_d;
    end
  bist_pattern_cnt #(.CNT_W(CNT_W), .PATTERNS(PATTERNS)) u_cnt (
    .clock(clock),
    .rst(rst),
    .clr(state_q == S_INIT),
    .inc(accept),
    .cnt(cnt),
    .tc(tc)
  );
  // Enables are a Moore decode; only RUN is gated by the CUT stall
  assign bus.lfsr_load = state_q == S_INIT;
  assign bus.misr_clr = state_q == S_INIT;
  assign bus.lfsr_en = accept;
  assign bus.misr_en = accept || (state_q == S_FLUSH);
  assign bus.pat_cnt = cnt;
  assign bus.busy = state_q inside {S_INIT, S_RUN, S_FLUSH, S_COMPARE};
  assign bus.done = state_q == S_DONE;
  assign bus.pass = pass_q;
  assign bus.sig_out = sig_q;
endmodule
